// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder that streams the operands
// one nibble per cycle through a single 4-bit ripple adder.
//
// four_bit_Full_Adder (helper, used only by nibble_serial_adder)
//   A_in, B_in [3:0]  nibble operands
//   C_in              carry-in
//   S_out [3:0]       nibble sum
//   C_out             nibble carry-out
//
// nibble_serial_adder
//   clk_in            rising-edge clock
//   rst_n_in          asynchronous active-low reset
//   start_in          request, accepted in IDLE or DONE
//   A_in, B_in        operands, captured on an accepted start
//   C_in              carry-in, captured on an accepted start
//   busy_out          high while nibbles are being added
//   done_out          one-cycle pulse when S_out/C_out/ovf_out are updated
//   S_out             sum, held until the next completion
//   C_out             unsigned carry-out of bit WIDTH-1
//   ovf_out           two's-complement signed overflow

module four_bit_Full_Adder (
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  input  logic       C_in,
  output logic [3:0] S_out,
  output logic       C_out
);

  assign {C_out, S_out} = {1'b0, A_in} + {1'b0, B_in} + {4'b0000, C_in};

endmodule

module nibble_serial_adder #(
  // Must be a multiple of 4 and at least 8.
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             C_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] S_out,
  output logic             C_out,
  output logic             ovf_out
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] partial_q;
  logic             carry_q;
  logic [IdxW-1:0]  idx_q;

  logic [IdxW+1:0]  bit_base;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       add_s;
  logic             add_c;
  logic [WIDTH-1:0] sum_final;
  logic             ovf_final;
  logic             last_nibble;

  // Bit offset of the current nibble (idx * 4).
  assign bit_base    = {idx_q, 2'b00};
  assign nib_a       = a_q[bit_base +: 4];
  assign nib_b       = b_q[bit_base +: 4];
  assign last_nibble = (idx_q == IdxW'(NIBBLES - 1));

  four_bit_Full_Adder u_adder (
    .A_in  (nib_a),
    .B_in  (nib_b),
    .C_in  (carry_q),
    .S_out (add_s),
    .C_out (add_c)
  );

  // On the last pass the top nibble comes straight from the adder; the lower
  // nibbles were written into partial_q on earlier passes.
  assign sum_final = {add_s, partial_q[WIDTH-5:0]};
  assign ovf_final = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[3] != a_q[WIDTH-1]);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      partial_q <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      S_out     <= '0;
      C_out     <= 1'b0;
      ovf_out   <= 1'b0;
    end else begin
      done_out <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          busy_out <= 1'b0;
          if (start_in) begin
            a_q      <= A_in;
            b_q      <= B_in;
            carry_q  <= C_in;
            idx_q    <= '0;
            busy_out <= 1'b1;
            state_q  <= StAdd;
          end else begin
            state_q  <= StIdle;
          end
        end
        StAdd: begin
          partial_q[bit_base +: 4] <= add_s;
          carry_q                  <= add_c;
          if (last_nibble) begin
            S_out    <= sum_final;
            C_out    <= add_c;
            ovf_out  <= ovf_final;
            idx_q    <= '0;
            busy_out <= 1'b0;
            done_out <= 1'b1;
            state_q  <= StDone;
          end else begin
            idx_q    <= idx_q + IdxW'(1);
          end
        end
        default: begin
          busy_out <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH = 16). Expected results
// are pushed to a scoreboard queue when a start is driven and popped when
// done_out is seen.

module tb_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_s;
    logic        exp_c;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        ovf;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] s_out;
  logic        c_out;
  logic        ovf_out;

  int n_vec = 0;
  int n_err = 0;
  res_t sb[$];

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .start_in (start),
    .A_in     (a_in),
    .B_in     (b_in),
    .C_in     (c_in),
    .busy_out (busy),
    .done_out (done),
    .S_out    (s_out),
    .C_out    (c_out),
    .ovf_out  (ovf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    vec_t v;
    logic [16:0] full;
    full = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
    v.a = a;
    v.b = b;
    v.cin = cin;
    v.exp_s = full[15:0];
    v.exp_c = full[16];
    v.exp_ovf = (a[15] == b[15]) && (full[15] != a[15]);
    return v;
  endfunction

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic cin,
                              input logic [15:0] s, input logic c, input logic ovf);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.exp_s = s; v.exp_c = c; v.exp_ovf = ovf;
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    res_t r;
    r.s = v.exp_s;
    r.c = v.exp_c;
    r.ovf = v.exp_ovf;
    sb.push_back(r);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected done", 32'(done), 32'd0);
      end else begin
        res_t r;
        r = sb.pop_front();
        chk("sum", 32'(s_out), 32'(r.s));
        chk("carry", 32'(c_out), 32'(r.c));
        chk("ovf", 32'(ovf_out), 32'(r.ovf));
      end
    end
  end

  // Issue one operation from IDLE and check handshake timing.
  task automatic do_op(input vec_t v);
    int cyc;
    int busy_cnt;
    a_in = v.a; b_in = v.b; c_in = v.cin; start = 1'b1;
    push_exp(v);
    @(posedge clk); #1;
    start = 1'b0;
    // Operands after acceptance must not matter.
    a_in = 16'($urandom); b_in = 16'($urandom); c_in = 1'($urandom);
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd4);
    chk("busy cycles", 32'(busy_cnt), 32'd4);
    @(posedge clk); #1;
    chk("done one cycle", 32'(done), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int cyc;
    int dones;
    logic held;

    vecs[0] = mk(16'h0005, 16'h0006, 1'b0, 16'h000B, 1'b0, 1'b0);
    vecs[1] = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    vecs[2] = mk(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    vecs[3] = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    vecs[4] = mk(16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0);
    vecs[5] = mk(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    for (int i = 6; i < 10; i++) begin
      vecs[i] = model(16'($urandom), 16'($urandom), 1'($urandom));
    end

    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sum", 32'(s_out), 32'd0);
    chk("reset carry", 32'(c_out), 32'd0);
    chk("reset ovf", 32'(ovf_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i]);
    end

    // start pulsed during ADD is ignored.
    a_in = 16'h00FF; b_in = 16'h0F00; c_in = 1'b1; start = 1'b1;
    push_exp(vecs[4]);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a_in = 16'h1111; b_in = 16'h1111; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    chk("mid-add start done count", 32'(dones), 32'd1);
    chk("mid-add start idle", 32'(busy), 32'd0);

    // Back-to-back: start held high through DONE.
    a_in = 16'h0005; b_in = 16'h0006; c_in = 1'b0; start = 1'b1;
    push_exp(vecs[0]);
    @(posedge clk); #1;
    a_in = 16'h0008; b_in = 16'h0007;
    push_exp(mk(16'h0008, 16'h0007, 1'b0, 16'h000F, 1'b0, 1'b0));
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b first latency", 32'(cyc), 32'd4);
    @(posedge clk); #1;
    chk("b2b no idle gap", 32'(busy), 32'd1);
    chk("b2b holds first sum", 32'(s_out), 32'h000B);
    start = 1'b0;
    a_in = 16'($urandom); b_in = 16'($urandom);
    held = 1'b1;
    cyc = 0;
    while (!done && cyc < 20) begin
      if (s_out !== 16'h000B) held = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b second latency", 32'(cyc), 32'd4);
    chk("b2b sum stable", 32'(held), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset two cycles into ADD aborts the operation.
    a_in = 16'h1234; b_in = 16'h1111; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst sum", 32'(s_out), 32'd0);
    chk("async rst carry", 32'(c_out), 32'd0);
    chk("async rst ovf", 32'(ovf_out), 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("async rst no done", 32'(dones), 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(vecs[0]);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
